// File: rtl/pixel_io_pkg.sv
// Shared frame geometry defaults, FSM encoding and small helpers for the
// pixel stream endpoint.
package pixel_io_pkg;

  localparam int IMG_W_DEFAULT = 256;
  localparam int IMG_H_DEFAULT = 256;
  localparam int NPIX_DEFAULT  = IMG_W_DEFAULT * IMG_H_DEFAULT;
  localparam int DW_DEFAULT    = 9;
  localparam int AW_DEFAULT    = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_PROC = 3'd2,
    UNLOAD    = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  // Input pixels are only legal while the endpoint is collecting a frame.
  function automatic logic in_forbidden(input state_t s);
    case (s)
      WAIT_PROC, UNLOAD, DRAIN: in_forbidden = 1'b1;
      default:                  in_forbidden = 1'b0;
    endcase
  endfunction

  // Frame ingest may start or continue only in these states.
  function automatic logic in_accepting(input state_t s);
    case (s)
      IDLE, LOAD: in_accepting = 1'b1;
      default:    in_accepting = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pixel_stream_io_raster_counter.sv
// Raster address counter: counts 0..NPIX-1 on enable and wraps back to 0.
module raster_counter #(
  parameter int AW   = 16,
  parameter int NPIX = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  output logic [AW-1:0] count,
  output logic          last
);

  localparam logic [AW-1:0] LAST_VAL = AW'(NPIX - 1);

  logic [AW-1:0] count_r;

  assign count = count_r;
  assign last  = (count_r == LAST_VAL);

  // Count register; clear has priority, wrap after the final raster address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {AW{1'b0}};
    end else if (clear) begin
      count_r <= {AW{1'b0}};
    end else if (enable) begin
      if (last) begin
        count_r <= {AW{1'b0}};
      end else begin
        count_r <= count_r + AW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_stream_io.sv
// Frame-level stream endpoint: ingests one raster frame into the frame RAM and,
// once the filter core is done, streams the result RAM out as NPIX samples.
module pixel_stream_io
  import pixel_io_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic        [AW-1:0] in_addr,
  output logic                 wr_en,
  output logic signed [DW-1:0] wr_data,
  output logic                 frame_in_done,
  input  logic                 proc_done,
  output logic                 rd_en,
  input  logic signed [DW-1:0] rd_data,
  output logic                 out_valid,
  output logic        [AW-1:0] out_addr,
  output logic signed [DW-1:0] out_data,
  output logic                 protocol_err
);

  localparam int NPIX = IMG_W * IMG_H;

  state_t state_r;
  state_t state_s;

  logic [AW-1:0] wcnt_s;
  logic          wlast_s;
  logic [AW-1:0] rcnt_s;
  logic          rlast_s;

  logic          accept_s;
  logic          illegal_s;

  logic [AW-1:0] in_addr_r;
  logic          wr_en_r;
  logic [DW-1:0] wr_data_r;
  logic          frame_done_r;
  logic          rd_en_r;
  logic          rd_pend_r;
  logic [AW-1:0] rd_addr_pend_r;
  logic          out_valid_r;
  logic [AW-1:0] out_addr_r;
  logic [DW-1:0] out_data_r;
  logic          err_r;

  assign accept_s  = in_valid & in_accepting(state_r);
  assign illegal_s = in_valid & in_forbidden(state_r);

  // wcnt is already 0 while unloading; the clear only guards against upsets.
  raster_counter #(
    .AW   (AW),
    .NPIX (NPIX)
  ) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (accept_s),
    .clear  (state_r == UNLOAD),
    .count  (wcnt_s),
    .last   (wlast_s)
  );

  raster_counter #(
    .AW   (AW),
    .NPIX (NPIX)
  ) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (rd_en_r),
    .clear  (state_r == IDLE),
    .count  (rcnt_s),
    .last   (rlast_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DRAIN holds until the last in-flight read has landed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = wlast_s ? WAIT_PROC : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (in_valid && wlast_s) begin
          state_s = WAIT_PROC;
        end else begin
          state_s = LOAD;
        end
      end
      WAIT_PROC: begin
        if (proc_done) begin
          state_s = UNLOAD;
        end else begin
          state_s = WAIT_PROC;
        end
      end
      UNLOAD: begin
        if (rlast_s) begin
          state_s = DRAIN;
        end else begin
          state_s = UNLOAD;
        end
      end
      DRAIN: begin
        if (rd_pend_r) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Ingest-side registers: write strobe, address and data share one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r      <= 1'b0;
      in_addr_r    <= {AW{1'b0}};
      wr_data_r    <= {DW{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      wr_en_r      <= accept_s;
      frame_done_r <= accept_s & wlast_s;
      if (accept_s) begin
        in_addr_r <= wcnt_s;
        wr_data_r <= in_data;
      end
    end
  end

  // Egress pipeline: rd_en -> RAM (1 cycle) -> output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_r        <= 1'b0;
      rd_pend_r      <= 1'b0;
      rd_addr_pend_r <= {AW{1'b0}};
      out_valid_r    <= 1'b0;
      out_addr_r     <= {AW{1'b0}};
      out_data_r     <= {DW{1'b0}};
    end else begin
      rd_en_r     <= (state_s == UNLOAD);
      rd_pend_r   <= rd_en_r;
      out_valid_r <= rd_pend_r;
      if (rd_en_r) begin
        rd_addr_pend_r <= rcnt_s;
      end
      if (rd_pend_r) begin
        out_addr_r <= rd_addr_pend_r;
        out_data_r <= rd_data;
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | illegal_s;
    end
  end

  assign in_addr       = in_addr_r;
  assign wr_en         = wr_en_r;
  assign wr_data       = wr_data_r;
  assign frame_in_done = frame_done_r;
  assign rd_en         = rd_en_r;
  assign out_valid     = out_valid_r;
  assign out_addr      = out_addr_r;
  assign out_data      = out_data_r;
  assign protocol_err  = err_r;

endmodule

// File: tb/tb_pixel_stream_io.sv
// Scoreboard bench for pixel_stream_io on a reduced 32x32 frame.
module tb_pixel_stream_io;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int DW    = 9;
  localparam int AW    = 10;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } samp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          proc_done = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] in_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          frame_in_done;
  logic          rd_en;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          protocol_err;

  int n_tests  = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  int rptr;

  samp_t wq[$];
  samp_t oq[$];
  logic [DW-1:0] ram [NPIX];

  pixel_stream_io #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_addr       (in_addr),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .frame_in_done (frame_in_done),
    .proc_done     (proc_done),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  // Result RAM model: 1-cycle read latency, sequential address per rd_en.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr    <= 0;
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= ram[rptr];
      rptr    <= (rptr + 1) % NPIX;
    end
  end

  function automatic logic [DW-1:0] pix(input int i);
    int v;
    v = (i % 512) - 256;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] res(input int i);
    int v;
    v = -(i % 256);
    return v[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Monitor: pops expected writes and output samples whenever the DUT presents them.
  initial forever begin
    samp_t e;
    @(negedge clk);
    if (rst) begin
      if (wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL wr_unexpected: write at addr %0d data 0x%0h, none pending", in_addr, wr_data);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(in_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (frame_in_done) begin
        done_cnt++;
        chk("done_last_addr", 32'(in_addr), 32'(NPIX - 1));
      end
      if (out_valid) begin
        if (oq.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL out_unexpected: sample at addr %0d data 0x%0h, none pending", out_addr, out_data);
        end else begin
          e = oq.pop_front();
          chk("out_addr", 32'(out_addr), 32'(e.a));
          chk("out_data", 32'(out_data), 32'(e.d));
        end
      end
    end
  end

  task automatic load_frame(input int pause_at, input int pause_len);
    samp_t e;
    int w0;
    int d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < NPIX; i++) begin
      @(posedge clk); #1;
      if (i == pause_at) begin
        in_valid = 1'b0;
        repeat (pause_len) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pix(i);
      e.a = AW'(i);
      e.d = pix(i);
      wq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("frame_writes", 32'(wr_cnt - w0), 32'(NPIX));
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic do_unload(input int inject_at, input int abort_at);
    samp_t e;
    int    k;
    int    gaps;
    logic  injected;
    for (int i = 0; i < NPIX; i++) begin
      e.a = AW'(i);
      e.d = res(i);
      oq.push_back(e);
    end
    @(posedge clk); #1;
    proc_done = 1'b1;
    @(posedge clk); #1;
    proc_done = 1'b0;
    chk("rd_en_after_proc_done", 32'(rd_en), 32'd1);
    chk("out_valid_lat0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("out_valid_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("out_valid_lat2", 32'(out_valid), 32'd1);
    chk("first_out_addr", 32'(out_addr), 32'd0);
    k = 0;
    gaps = 0;
    injected = 1'b0;
    while (oq.size() != 0 && k < NPIX + 20) begin
      in_valid = 1'b0;
      if (!out_valid) gaps++;
      if (inject_at >= 0 && !injected && out_valid && out_addr == AW'(inject_at)) begin
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        injected = 1'b1;
      end
      if (abort_at >= 0 && out_valid && out_addr == AW'(abort_at)) begin
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_err_cleared", 32'(protocol_err), 32'd0);
        oq.delete();
        wq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("out_queue_drained", 32'(oq.size()), 32'd0);
    chk("out_valid_gaps", 32'(gaps), 32'd0);
    chk("out_valid_falls", 32'(out_valid), 32'd0);
    chk("rd_en_falls", 32'(rd_en), 32'd0);
    if (inject_at >= 0) begin
      chk("protocol_err_set", 32'(protocol_err), 32'd1);
    end
  endtask

  initial begin
    logic busy;
    for (int i = 0; i < NPIX; i++) ram[i] = res(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_addr", 32'(in_addr), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_done", 32'(frame_in_done), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_protocol_err", 32'(protocol_err), 32'd0);
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_rd_en", 32'(rd_en), 32'd0);

    // proc_done while idle must not start an unload.
    proc_done = 1'b1;
    @(posedge clk); #1;
    proc_done = 1'b0;
    busy = 1'b0;
    repeat (4) begin
      busy = busy | rd_en | out_valid;
      @(posedge clk); #1;
    end
    chk("proc_done_ignored_idle", 32'(busy), 32'd0);

    load_frame(-1, 0);
    chk("frames_done_1", 32'(done_cnt), 32'd1);
    do_unload(-1, -1);
    chk("err_clean_unload", 32'(protocol_err), 32'd0);

    load_frame(1000, 10);
    chk("frames_done_2", 32'(done_cnt), 32'd2);
    do_unload(500, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("protocol_err_sticky", 32'(protocol_err), 32'd1);

    load_frame(-1, 0);
    chk("frames_done_3", 32'(done_cnt), 32'd3);
    do_unload(-1, 300);
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_out_valid", 32'(out_valid), 32'd0);

    load_frame(-1, 0);
    chk("frames_done_4", 32'(done_cnt), 32'd4);
    do_unload(-1, -1);
    chk("err_after_reset_frame", 32'(protocol_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d fails=%0d", n_tests, n_fails);
    $fatal(1, "watchdog expired");
  end

endmodule
